// File: rtl/kf76489_pkg.sv
// Shared types and constants for the KF76489 register sequencer: FSM states, channel codes
// and register-type bit.
package kf76489_pkg;

  localparam int unsigned DEFAULT_READY_CYCLES = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StBusy,
    StRelease
  } state_e;

  typedef enum logic [1:0] {
    ChTone0 = 2'd0,
    ChTone1 = 2'd1,
    ChTone2 = 2'd2,
    ChNoise = 2'd3
  } channel_e;

  typedef enum logic {
    RegFreq  = 1'b0,
    RegAtten = 1'b1
  } reg_type_e;

  // One-hot tone select; the noise channel maps to no tone bit.
  function automatic logic [2:0] tone_onehot(channel_e ch);
    tone_onehot = (ch == ChNoise) ? 3'b000 : (3'b001 << ch);
  endfunction

endpackage

// File: rtl/kf76489_register_sequencer_if.sv
// CPU-side pin bundle of the KF76489: chip select, write strobe, data byte and READY.
interface kf76489_register_sequencer_if;
  logic       chip_enable_n;
  logic       write_enable_n;
  logic [7:0] data_bus;
  logic       ready;

  modport master (output chip_enable_n, output write_enable_n, output data_bus, input ready);
  modport slave  (input chip_enable_n, input write_enable_n, input data_bus, output ready);
endinterface

// File: rtl/kf76489_register_sequencer.sv
// Captures CPU writes, decodes the SN76489 latch/data protocol into one-clock generator write
// strobes, and holds READY low for READY_CYCLES chip-clock enables per write.
module kf76489_register_sequencer
  import kf76489_pkg::*;
#(
  parameter int unsigned READY_CYCLES = DEFAULT_READY_CYCLES
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clock_enable,
  kf76489_register_sequencer_if.slave       bus,
  output logic [7:0]                        internal_data_bus,
  output logic [2:0]                        write_tone_frequency_low,
  output logic [2:0]                        write_tone_frequency_high,
  output logic [2:0]                        write_tone_attenuation,
  output logic                              write_noise_control,
  output logic                              write_noise_attenuation,
  output logic [2:0]                        latched_register
);

  localparam int unsigned CntW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(READY_CYCLES - 1);

  state_e          state;
  logic            ready_q;
  logic [CntW-1:0] busy_cnt;

  logic      request;
  logic      is_latch;
  channel_e  cmd_ch, lat_ch;
  reg_type_e cmd_type, lat_type;

  logic [2:0] freq_low_d, freq_high_d, tone_att_d;
  logic       noise_ctl_d, noise_att_d;

  assign request  = !bus.chip_enable_n && !bus.write_enable_n;
  assign is_latch = bus.data_bus[0];
  // D1 is the channel MSB, so the bus bits are reversed relative to their weight.
  assign cmd_ch   = channel_e'({bus.data_bus[1], bus.data_bus[2]});
  assign cmd_type = reg_type_e'(bus.data_bus[3]);
  assign lat_ch   = channel_e'(latched_register[2:1]);
  assign lat_type = reg_type_e'(latched_register[0]);
  assign bus.ready = ready_q;

  always_comb begin
    freq_low_d  = 3'b000;
    freq_high_d = 3'b000;
    tone_att_d  = 3'b000;
    noise_ctl_d = 1'b0;
    noise_att_d = 1'b0;
    if (is_latch) begin
      if (cmd_ch == ChNoise) begin
        noise_ctl_d = (cmd_type == RegFreq);
        noise_att_d = (cmd_type == RegAtten);
      end else if (cmd_type == RegAtten) begin
        tone_att_d = tone_onehot(cmd_ch);
      end else begin
        freq_low_d = tone_onehot(cmd_ch);
      end
    end else if (lat_type == RegFreq) begin
      // Data bytes only extend tone frequencies; noise control and attenuation ignore them.
      freq_high_d = tone_onehot(lat_ch);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                     <= StRelease;
      ready_q                   <= 1'b1;
      busy_cnt                  <= '0;
      internal_data_bus         <= 8'h00;
      latched_register          <= 3'b000;
      write_tone_frequency_low  <= 3'b000;
      write_tone_frequency_high <= 3'b000;
      write_tone_attenuation    <= 3'b000;
      write_noise_control       <= 1'b0;
      write_noise_attenuation   <= 1'b0;
    end else begin
      write_tone_frequency_low  <= 3'b000;
      write_tone_frequency_high <= 3'b000;
      write_tone_attenuation    <= 3'b000;
      write_noise_control       <= 1'b0;
      write_noise_attenuation   <= 1'b0;
      case (state)
        StIdle: begin
          if (request) begin
            internal_data_bus         <= bus.data_bus;
            if (is_latch) begin
              latched_register <= {bus.data_bus[1], bus.data_bus[2], bus.data_bus[3]};
            end
            write_tone_frequency_low  <= freq_low_d;
            write_tone_frequency_high <= freq_high_d;
            write_tone_attenuation    <= tone_att_d;
            write_noise_control       <= noise_ctl_d;
            write_noise_attenuation   <= noise_att_d;
            ready_q                   <= 1'b0;
            state                     <= StStrobe;
          end
        end
        StStrobe: begin
          busy_cnt <= '0;
          state    <= StBusy;
        end
        StBusy: begin
          if (clock_enable) begin
            if (busy_cnt == LastCnt) begin
              busy_cnt <= '0;
              ready_q  <= 1'b1;
              state    <= StRelease;
            end else begin
              busy_cnt <= busy_cnt + 1'b1;
            end
          end
        end
        StRelease: begin
          if (!request) begin
            state <= StIdle;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state   <= StRelease;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf76489_register_sequencer.sv
// Randomized scoreboard bench for kf76489_register_sequencer: writes push expected responses,
// a monitor compares them at each accept and checks the READY-low enable count.
module tb_kf76489_register_sequencer;

  localparam int unsigned RC = 32;

  typedef struct packed {
    logic [10:0] strb;
    logic [7:0]  idb;
    logic [2:0]  lr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clock_enable = 1'b0;
  logic [7:0] internal_data_bus;
  logic [2:0] write_tone_frequency_low, write_tone_frequency_high, write_tone_attenuation;
  logic write_noise_control, write_noise_attenuation;
  logic [2:0] latched_register;
  logic [10:0] strb_act;

  kf76489_register_sequencer_if bus ();

  kf76489_register_sequencer #(.READY_CYCLES(RC)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .clock_enable              (clock_enable),
    .bus                       (bus),
    .internal_data_bus         (internal_data_bus),
    .write_tone_frequency_low  (write_tone_frequency_low),
    .write_tone_frequency_high (write_tone_frequency_high),
    .write_tone_attenuation    (write_tone_attenuation),
    .write_noise_control       (write_noise_control),
    .write_noise_attenuation   (write_noise_attenuation),
    .latched_register          (latched_register)
  );

  assign strb_act = {write_tone_frequency_low, write_tone_frequency_high,
                     write_tone_attenuation, write_noise_control, write_noise_attenuation};

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   ce_mode = 0;
  logic [2:0] model_lr = 3'b000;

  // Monitor state
  logic prev_ready = 1'b1;
  bit   counting = 0;
  int   pulse_cnt = 0;
  int   clk_low = 0;
  int   fall_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Register number r = 2*channel + attenuation, as in the SN76489 register map.
  function automatic logic [10:0] expected_strobe(input logic [7:0] b, input logic [2:0] lr);
    int ch, att, r;
    logic [10:0] s;
    s = '0;
    if (b[0]) begin
      ch = {b[1], b[2]};
      att = b[3];
    end else begin
      ch = lr[2:1];
      att = lr[0];
    end
    r = ch * 2 + att;
    if (b[0]) begin
      if (r == 7) s[0] = 1'b1;
      else if (r == 6) s[1] = 1'b1;
      else if (att == 1) s[2 + ch] = 1'b1;
      else s[8 + ch] = 1'b1;
    end else if (r < 6 && att == 0) begin
      s[5 + ch] = 1'b1;
    end
    return s;
  endfunction

  initial begin
    int phase = 0;
    forever begin
      @(posedge clock);
      #1;
      phase = (phase + 1) % 4;
      if (ce_mode == 1) clock_enable = (phase == 0);
      else clock_enable = ($urandom_range(0, 2) == 0);
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      counting   = 0;
      prev_ready = 1'b1;
    end else begin
      if (prev_ready && !bus.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got strobes %b, expected no accept", strb_act);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobes", 32'(strb_act), 32'(e.strb));
          check("internal_data_bus", 32'(internal_data_bus), 32'(e.idb));
          check("latched_register", 32'(latched_register), 32'(e.lr));
        end
        counting  = 1;
        pulse_cnt = 0;
        clk_low   = 1;
        fall_mode = ce_mode;
      end else begin
        check("no_stray_strobe", 32'(strb_act), 32'h0);
        if (!bus.ready && counting) begin
          clk_low++;
          if (clock_enable) pulse_cnt++;
        end
        if (!prev_ready && bus.ready && counting) begin
          check("ready_low_enables", 32'(pulse_cnt), RC);
          if (fall_mode == 1) begin
            checks++;
            if (clk_low < 4 * RC - 4 || clk_low > 4 * RC + 4) begin
              errors++;
              $display("FAIL ready_low_clocks: got %0d, expected %0d +/- 4", clk_low, 4 * RC);
            end
          end
          counting = 0;
        end
      end
      prev_ready = bus.ready;
    end
  end

  task automatic wait_ready_idle();
    int waited = 0;
    bus.chip_enable_n  = 1'b1;
    bus.write_enable_n = 1'b1;
    @(posedge clock);
    #1;
    while (!bus.ready && waited < 3000) begin
      @(posedge clock);
      #1;
      waited++;
    end
    checks++;
    if (waited >= 3000) begin
      errors++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected ready=1", waited);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [7:0] b, input int hold);
    exp_t e;
    wait_ready_idle();
    e.strb = expected_strobe(b, model_lr);
    if (b[0]) model_lr = {b[1], b[2], b[3]};
    e.idb = b;
    e.lr  = model_lr;
    exp_q.push_back(e);
    bus.data_bus       = b;
    bus.chip_enable_n  = 1'b0;
    bus.write_enable_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      bus.data_bus = 8'($urandom);
    end
    bus.chip_enable_n  = 1'b1;
    bus.write_enable_n = 1'b1;
  endtask

  initial begin
    // Reset with a latch write held active: it must never be accepted.
    bus.chip_enable_n  = 1'b0;
    bus.write_enable_n = 1'b0;
    bus.data_bus       = 8'hD1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("held_reset_ready", 32'(bus.ready), 32'h1);
    end
    check("reset_idb", 32'(internal_data_bus), 32'h00);
    check("reset_lr", 32'(latched_register), 32'h0);

    do_write(8'hD1, 1);
    do_write({4'($urandom), 4'b0101}, 1);
    do_write(8'h3C, 2);
    do_write(8'h0F, 1);
    do_write(8'h3C, 1);

    // Slow enables; a second request during BUSY and a request held past BUSY are ignored.
    wait_ready_idle();
    ce_mode = 1;
    do_write(8'($urandom), 1);
    repeat (20) @(posedge clock);
    #1;
    bus.data_bus       = 8'($urandom);
    bus.chip_enable_n  = 1'b0;
    bus.write_enable_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    bus.chip_enable_n  = 1'b1;
    bus.write_enable_n = 1'b1;
    do_write(8'($urandom), 200);
    wait_ready_idle();
    ce_mode = 0;

    for (int n = 0; n < 30; n++) do_write(8'($urandom), $urandom_range(1, 3));

    // Reset during BUSY drops everything; a following write still gets the full count.
    do_write(8'($urandom), 1);
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_lr = 3'b000;
    exp_q.delete();
    @(negedge clock);
    check("mid_reset_ready", 32'(bus.ready), 32'h1);
    check("mid_reset_strobes", 32'(strb_act), 32'h0);
    check("mid_reset_idb", 32'(internal_data_bus), 32'h00);
    check("mid_reset_lr", 32'(latched_register), 32'h0);
    do_write(8'h3C, 1);
    do_write(8'($urandom), 1);

    wait_ready_idle();
    repeat (3) @(posedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
